// File: rtl/sar_result_averager_pkg.sv
// sar_pkg: shared types and defaults for the SAR result averager.
package sar_pkg;
    localparam int SAR_W = 8;
    localparam int DEF_LOG2_AVG = 2;
    localparam int DEF_CONV_CYCLES = 10;
    typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;
endpackage

// File: rtl/sar_result_averager_if.sv
// sar_result_averager_if: valid/ready result channel toward the readout logic.
interface sar_result_averager_if;
    import sar_pkg::*;
    logic [SAR_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;
    modport master (output res_data, res_valid, input res_ready);
    modport slave  (input res_data, res_valid, output res_ready);
endinterface

// File: rtl/sar_window_accumulator.sv
// sar_window_accumulator: sums 2^LOG2_AVG samples and reports the truncated mean.
module sar_window_accumulator
    import sar_pkg::*;
#(
    parameter int LOG2_AVG = DEF_LOG2_AVG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add,
    input  logic [SAR_W-1:0] sample,
    output logic             done,
    output logic [SAR_W-1:0] avg
);
    logic [SAR_W+LOG2_AVG-1:0] acc, sum;
    logic [LOG2_AVG:0]         cnt;
    assign sum  = acc + (SAR_W+LOG2_AVG)'(sample);
    assign done = add && cnt == (LOG2_AVG+1)'((1 << LOG2_AVG) - 1);
    assign avg  = SAR_W'(sum >> LOG2_AVG);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear || done) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/sar_result_averager.sv
// sar_result_averager: restarts the SAR, captures and averages its results, publishes over valid/ready.
// Optional SAR_AVG_OVERRUN_CNT_EN adds a saturating 8-bit overrun event counter.
module sar_result_averager
    import sar_pkg::*;
#(
    parameter int LOG2_AVG    = DEF_LOG2_AVG,
    parameter int CONV_CYCLES = DEF_CONV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [SAR_W-1:0] data_in,
    output logic             sar_rst,
    output logic             overrun,
`ifdef SAR_AVG_OVERRUN_CNT_EN
    output logic [7:0]       overrun_cnt,
`endif
    sar_result_averager_if.master res
);
    state_t           state;
    logic [7:0]       wait_cnt;
    logic             done;
    logic [SAR_W-1:0] avg;
    logic             lost;
    sar_window_accumulator #(.LOG2_AVG(LOG2_AVG)) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .add    (state == CAPTURE),
        .sample (~data_in),
        .done   (done),
        .avg    (avg)
    );
    // a publish only loses data when the previous result is still pending and not leaving
    assign lost = done && res.res_valid && !res.res_ready;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            sar_rst  <= 1'b1;
        end else
            case (state)
                IDLE: begin
                    state   <= enable ? START : IDLE;
                    sar_rst <= 1'b1;
                end
                START: begin
                    state    <= enable ? WAIT : IDLE;
                    wait_cnt <= 8'(CONV_CYCLES - 1);
                    sar_rst  <= !enable;
                end
                WAIT: begin
                    state    <= !enable ? IDLE : wait_cnt == 0 ? CAPTURE : WAIT;
                    wait_cnt <= wait_cnt - 1'b1;
                    sar_rst  <= !enable;
                end
                default: begin
                    state   <= enable ? START : IDLE;
                    sar_rst <= 1'b1;
                end
            endcase
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            res.res_data  <= '0;
            res.res_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (done) res.res_data <= avg;
            res.res_valid <= done || (res.res_valid && !res.res_ready);
            overrun       <= overrun || lost;
        end
`ifdef SAR_AVG_OVERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) overrun_cnt <= '0;
        else if (lost && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_sar_result_averager.sv
// tb_sar_result_averager: directed checks of the averager with default and minimum-window configurations.
module tb_sar_result_averager;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable, enable_b;
    logic [7:0] data_in, data_b;
    logic       sar_rst, sar_rst_b, overrun, overrun_b;
    int         vectors = 0;
    int         miss = 0;
`ifdef SAR_AVG_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt, overrun_cnt_b;
`endif
    sar_result_averager_if ra ();
    sar_result_averager_if rb ();
    always #5 clk = ~clk;
    sar_result_averager dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .sar_rst(sar_rst), .overrun(overrun),
`ifdef SAR_AVG_OVERRUN_CNT_EN
        .overrun_cnt(overrun_cnt),
`endif
        .res(ra.master)
    );
    sar_result_averager #(.LOG2_AVG(0), .CONV_CYCLES(9)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .data_in(data_b),
        .sar_rst(sar_rst_b), .overrun(overrun_b),
`ifdef SAR_AVG_OVERRUN_CNT_EN
        .overrun_cnt(overrun_cnt_b),
`endif
        .res(rb.master)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b1; enable = 1'b0; enable_b = 1'b0;
        data_in = 8'h00; data_b = 8'h00; ra.res_ready = 1'b0; rb.res_ready = 1'b0;
        tick(3);
        chk("rst_sar_rst", 32'(sar_rst), 1);
        chk("rst_valid", 32'(ra.res_valid), 0);
        chk("rst_data", 32'(ra.res_data), 0);
        chk("rst_overrun", 32'(overrun), 0);
        @(negedge clk) reset = 1'b0;
        tick(5);
        chk("idle_sar_rst", 32'(sar_rst), 1);
        data_in = 8'h5A; enable = 1'b1;
        tick(2);
        chk("wait_sar_rst_low", 32'(sar_rst), 0);
        tick(10);
        chk("capture_sar_rst_low", 32'(sar_rst), 0);
        tick(1);
        chk("restart_sar_rst_high", 32'(sar_rst), 1);
        tick(35);
        chk("const_valid_early", 32'(ra.res_valid), 0);
        tick(1);
        chk("const_valid", 32'(ra.res_valid), 1);
        chk("const_data", 32'(ra.res_data), 32'hA5);
        ra.res_ready = 1'b1;
        tick(1);
        chk("xfer_valid_drop", 32'(ra.res_valid), 0);
        ra.res_ready = 1'b0; data_in = 8'hFF;
        tick(11); data_in = 8'hFE;
        tick(12); data_in = 8'hFD;
        tick(12); data_in = 8'hFC;
        tick(12);
        chk("trunc_valid", 32'(ra.res_valid), 1);
        chk("trunc_data", 32'(ra.res_data), 32'h01);
        ra.res_ready = 1'b1;
        tick(1);
        ra.res_ready = 1'b0; data_in = 8'h00;
        tick(47);
        chk("full_data", 32'(ra.res_data), 32'hFF);
        chk("full_valid", 32'(ra.res_valid), 1);
        chk("full_overrun", 32'(overrun), 0);
        ra.res_ready = 1'b1;
        tick(1);
        chk("full_xfer", 32'(ra.res_valid), 0);
        ra.res_ready = 1'b0; data_in = 8'hEF;
        tick(47);
        chk("bp1_data", 32'(ra.res_data), 32'h10);
        chk("bp1_overrun", 32'(overrun), 0);
        data_in = 8'hDF;
        tick(48);
        chk("bp2_data", 32'(ra.res_data), 32'h20);
        chk("bp2_valid", 32'(ra.res_valid), 1);
        chk("bp2_overrun", 32'(overrun), 1);
`ifdef SAR_AVG_OVERRUN_CNT_EN
        chk("bp2_overrun_cnt", 32'(overrun_cnt), 1);
`endif
        ra.res_ready = 1'b1;
        tick(1);
        chk("bp_xfer_valid", 32'(ra.res_valid), 0);
        chk("overrun_sticky", 32'(overrun), 1);
        ra.res_ready = 1'b0; data_in = 8'hBF;
        tick(23);
        enable = 1'b0;
        tick(2);
        chk("drop_idle_sar_rst", 32'(sar_rst), 1);
        tick(3);
        data_in = 8'h7F; enable = 1'b1;
        tick(48);
        chk("resume_valid_early", 32'(ra.res_valid), 0);
        tick(1);
        chk("resume_valid", 32'(ra.res_valid), 1);
        chk("resume_data", 32'(ra.res_data), 32'h80);
        tick(3);
        #1 reset = 1'b1;
        #1;
        chk("midwait_rst_sar_rst", 32'(sar_rst), 1);
        chk("midwait_rst_valid", 32'(ra.res_valid), 0);
        chk("midwait_rst_data", 32'(ra.res_data), 0);
        chk("midwait_rst_overrun", 32'(overrun), 0);
`ifdef SAR_AVG_OVERRUN_CNT_EN
        chk("midwait_rst_cnt", 32'(overrun_cnt), 0);
`endif
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("post_rst_hold", {30'd0, sar_rst, ra.res_valid}, 32'h2);
        end
        data_b = 8'hCC; enable_b = 1'b1;
        tick(11);
        chk("b_valid_early", 32'(rb.res_valid), 0);
        tick(1);
        chk("b_valid", 32'(rb.res_valid), 1);
        chk("b_data", 32'(rb.res_data), 32'h33);
        rb.res_ready = 1'b1;
        tick(1);
        chk("b_xfer", 32'(rb.res_valid), 0);
        rb.res_ready = 1'b0; data_b = 8'hBB;
        tick(9);
        chk("b_valid2_early", 32'(rb.res_valid), 0);
        tick(1);
        chk("b_valid2", 32'(rb.res_valid), 1);
        chk("b_data2", 32'(rb.res_data), 32'h44);
        chk("b_overrun", 32'(overrun_b), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule

// File: doc/sar_result_averager.md
# sar_result_averager

Sequencer and post-processor directly downstream of the SAR/R2R DAC controller. It repeatedly restarts the SAR controller through its reset input and waits a fixed conversion time. It then captures the 8-bit result, re-inverts it to true polarity and averages 2^LOG2_AVG conversions. The averaged code is delivered to the sensor readout logic over a valid/ready handshake.

## Interface
- `LOG2_AVG`, 2: log2 of samples per averaging window; legal 0..6.
- `CONV_CYCLES`, 10: cycles between SAR release and result capture; legal 9..255, since the SAR needs 1 set cycle plus 8 evaluate cycles.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run conversions while high.
- `data_in`  in  8  SAR result bus, inverted polarity, as driven by the SAR controller.
- `sar_rst`  out  1  drives the SAR controller reset; high restarts a conversion.
- `res_data`  out  8  averaged result, true polarity.
- `res_valid`  out  1  `res_data` holds an unconsumed result.
- `res_ready`  in  1  consumer accepts `res_data`.
- `overrun`  out  1  sticky flag: an unconsumed result was overwritten.

## Operation
- **States:** IDLE, START, WAIT, CAPTURE.
- **IDLE**
  - `sar_rst`=1.
  - Accumulator and sample count are cleared.
  - Moves to START when `enable`=1.
- **START:** `sar_rst`=1 for exactly one cycle, then WAIT. The wait counter loads CONV_CYCLES-1.
- **WAIT**
  - `sar_rst`=0 so the SAR runs.
  - The counter decrements; when it reaches 0 the FSM moves to CAPTURE.
- **CAPTURE**
  - The sample is `~data_in`. `acc <= acc + sample`, where `acc` is 8+LOG2_AVG bits wide and cannot overflow.
  - When the sample count reaches 2^LOG2_AVG-1:
    - publish `res_data <= (acc + sample) >> LOG2_AVG`, truncating;
    - set `res_valid`;
    - clear `acc` and the count.
  - Next state is START if `enable`=1, otherwise IDLE.
- **`enable` falls in START or WAIT:** the FSM goes to IDLE on the next cycle and the partial window is discarded. `res_valid`/`res_data` are untouched.
- **Handshake**
  - A transfer occurs on a cycle with `res_valid` && `res_ready`; `res_valid` clears on the next edge.
  - `res_data` is stable while `res_valid`=1 and no new result is published.
- **Publish while `res_valid`=1 and no transfer that cycle:**
  - `res_data` is overwritten.
  - `res_valid` stays 1.
  - `overrun` is set. It clears only on `reset`.
- **Publish on the same cycle as a transfer:** the new result is loaded, `res_valid` stays 1, and no overrun is flagged.
- **`reset` asserted at any time:**
  - FSM goes to IDLE; `acc` and counters go to 0.
  - Reset values: `sar_rst`=1, `res_data`=0, `res_valid`=0, `overrun`=0.

## Timing
- Sample period is CONV_CYCLES+2 cycles: 1 START + CONV_CYCLES WAIT + 1 CAPTURE.
- The first START is the cycle after `enable` is sampled high in IDLE.
- `res_valid` rises on the edge ending the last CAPTURE. The first result appears 1 + 2^LOG2_AVG·(CONV_CYCLES+2) cycles after `enable` rises.
- `data_in` is sampled at the end of CAPTURE, i.e. CONV_CYCLES+1 edges after `sar_rst` falls.
- No combinational path from `res_ready` to any output.

## Configuration
- **`SAR_AVG_OVERRUN_CNT_EN` defined:** adds output `overrun_cnt` (8 bits). It increments on every overrun event, saturates at 255 and resets to 0.
- **Undefined:** the port and counter are absent; only the sticky `overrun` bit exists.

## Structure
- **Shared package `sar_pkg`**
  - FSM state enum.
  - SAR data width (8).
  - Defaults for LOG2_AVG and CONV_CYCLES.
- **Sub-module `sar_window_accumulator`**
  - Holds the accumulator and sample counter.
  - Inputs: clear, add-strobe, sample.
  - Outputs: window-done pulse and averaged value.
- The top level holds the FSM, wait counter and output handshake register.

## Test plan
- **Reset:** assert `reset` mid-WAIT → `sar_rst`=1, `res_valid`=0, `res_data`=0x00, `overrun`=0 immediately; after release no START until `enable`=1.
- **Constant input:** defaults, `data_in`=0x5A constant, `enable`=1 → `res_data`=0xA5, `res_valid` high at cycle 1+4·12=49; `sar_rst` high once per 12 cycles.
- **Truncation:** true samples 0,1,2,3 (`data_in` 0xFF,0xFE,0xFD,0xFC) → `res_data`=0x01. Full scale (`data_in`=0x00 ×4) → 0xFF with no wrap.
- **Backpressure:** `res_ready`=0 across two windows with true values 0x10 then 0x20 → `res_data`=0x20, `res_valid`=1, `overrun`=1; with the macro, `overrun_cnt`=1. Then `res_ready`=1 → `res_valid` drops after one cycle.
- **Enable drop:** deassert `enable` after 2 of 4 samples, resume → next result averages only 4 fresh samples.
- **LOG2_AVG=0, CONV_CYCLES=9:** every sample is published directly, one result per 11 cycles.
